auth_seq: RTL

//  Parametrised successor to the single-byte power-up authorisation block. Sits between

---
 rtl/auth_if.sv | 15 +
 rtl/auth_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/auth_if.sv
// auth_if: byte handshake between UART_rcv and auth_seq.
//   rx_data    received byte
//   rx_rdy     byte valid; held by the UART until clr_rx_rdy is seen
//   clr_rx_rdy one-cycle pulse from the consumer that clears rx_rdy
// Handshake: a byte is transferred on a clk edge where rx_rdy=1 and
// clr_rx_rdy=0; the consumer answers with clr_rx_rdy=1 for exactly the
// following cycle, during which rx_rdy is ignored.
interface auth_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       clr_rx_rdy;

  modport master (output rx_data, output rx_rdy, input  clr_rx_rdy);
  modport slave  (input  rx_data, input  rx_rdy, output clr_rx_rdy);
endinterface

// File: rtl/auth_seq.sv
// auth_seq: power-up authorisation sequencer.
// Matches a multi-byte GO key to raise pwr_up, accepts a STOP code with a
// rider-off power-down delay, and locks out after repeated bad attempts.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   rx         auth_if.slave byte intake (rx_data, rx_rdy, clr_rx_rdy)
//   rider_off  load-cell sum below rider threshold
//   pwr_up     enables the balance controller
//   locked     high while in lockout
//   fail_cnt   consecutive bad-attempt count
//   o_state    current FSM state (debug)
module auth_seq #(
  parameter int          KEY_LEN   = 1,
  parameter logic [31:0] GO_KEY    = 32'h47,
  parameter logic [7:0]  STOP_CODE = 8'h53,
  parameter int          MAX_FAIL  = 3,
  parameter int          LOCK_CYC  = 1_000_000,
  parameter int          BYTE_TMO  = 500_000,
  parameter int          OFF_DLY   = 250_000
) (
  input  logic                          clk,
  input  logic                          rst,
  auth_if.slave                         rx,
  input  logic                          rider_off,
  output logic                          pwr_up,
  output logic                          locked,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic [1:0]                    o_state
);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int GW = $clog2(BYTE_TMO+1);
  localparam int LW = $clog2(LOCK_CYC+1);
  localparam int OW = $clog2(OFF_DLY+1);

  typedef enum logic [1:0] {IDLE = 2'd0, PWR = 2'd1, STOPPING = 2'd2, LOCKOUT = 2'd3} state_t;

  state_t          r_state, w_state_n;
  logic [1:0]      r_idx,   w_idx_n;
  logic [GW-1:0]   r_gap,   w_gap_n;
  logic [FW-1:0]   r_fail,  w_fail_n;
  logic [LW-1:0]   r_lock,  w_lock_n;
  logic [OW-1:0]   r_off,   w_off_n;
  logic            r_clr;

  logic            w_take, w_hit, w_last, w_matched, w_miss, w_tmo, w_stop;
  logic [7:0]      w_key_byte;
  logic [1:0]      w_m_idx;
  logic [GW-1:0]   w_m_gap;

  // The clear pulse itself blocks intake for one cycle, so a held rx_rdy is
  // never taken twice.
  assign w_take     = rx.rx_rdy & ~r_clr;
  assign w_key_byte = GO_KEY[{r_idx, 3'b000} +: 8];
  assign w_hit      = (rx.rx_data == w_key_byte);
  assign w_last     = (r_idx == 2'(KEY_LEN-1));
  assign w_matched  = w_take & w_hit & w_last;
  assign w_miss     = w_take & ~w_hit;
  assign w_stop     = w_take & (rx.rx_data == STOP_CODE);
  // A byte arriving on the expiry cycle suppresses the timeout.
  assign w_tmo      = ~w_take & (r_idx != 2'd0) & (r_gap >= GW'(BYTE_TMO-1));

  // Shared key matcher next-state; a mismatching byte restarts at index 0
  // without being re-tested as the first key byte.
  always_comb begin
    w_m_idx = r_idx;
    w_m_gap = r_gap;
    if (w_take) begin
      w_m_gap = '0;
      w_m_idx = (w_hit && !w_last) ? r_idx + 2'd1 : 2'd0;
    end else if (w_tmo) begin
      w_m_idx = 2'd0;
      w_m_gap = '0;
    end else if (r_idx != 2'd0 && r_gap < GW'(BYTE_TMO)) begin
      w_m_gap = r_gap + GW'(1);
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_gap_n   = r_gap;
    w_fail_n  = r_fail;
    w_lock_n  = r_lock;
    w_off_n   = r_off;
    case (r_state)
      IDLE: begin
        w_idx_n = w_m_idx;
        w_gap_n = w_m_gap;
        if (w_matched) begin
          w_state_n = PWR;
          w_fail_n  = '0;
        end else if (w_miss || w_tmo) begin
          if (r_fail >= FW'(MAX_FAIL-1)) begin
            w_fail_n  = FW'(MAX_FAIL);
            w_state_n = LOCKOUT;
            w_lock_n  = '0;
          end else begin
            w_fail_n = r_fail + FW'(1);
          end
        end
      end
      PWR: begin
        w_idx_n = 2'd0;
        w_gap_n = '0;
        if (w_stop) begin
          w_state_n = rider_off ? IDLE : STOPPING;
          w_off_n   = '0;
        end
      end
      STOPPING: begin
        w_idx_n = w_m_idx;
        w_gap_n = w_m_gap;
        if (!rider_off)                       w_off_n = '0;
        else if (r_off < OW'(OFF_DLY-1))      w_off_n = r_off + OW'(1);
        if (w_matched) begin
          w_state_n = PWR;
        end else if (rider_off && r_off >= OW'(OFF_DLY-1)) begin
          w_state_n = IDLE;
          w_idx_n   = 2'd0;
          w_gap_n   = '0;
        end
      end
      default: begin  // LOCKOUT
        w_idx_n = 2'd0;
        w_gap_n = '0;
        if (r_lock >= LW'(LOCK_CYC-1)) begin
          w_state_n = IDLE;
          w_fail_n  = '0;
          w_lock_n  = '0;
        end else begin
          w_lock_n = r_lock + LW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_gap   <= '0;
      r_fail  <= '0;
      r_lock  <= '0;
      r_off   <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_gap   <= w_gap_n;
      r_fail  <= w_fail_n;
      r_lock  <= w_lock_n;
      r_off   <= w_off_n;
      r_clr   <= w_take;
    end
  end

  assign rx.clr_rx_rdy = r_clr;
  assign pwr_up        = (r_state == PWR) || (r_state == STOPPING);
  assign locked        = (r_state == LOCKOUT);
  assign fail_cnt      = r_fail;
  assign o_state       = r_state;
endmodule
